// File: rtl/fadd_arbiter_if.sv
// fadd_arbiter_if: request, shared-subtractor and response signals of fadd_arbiter
//   master: requesters plus subtractor (drive req/a/b/op and fpu_y/fpu_ovf)
//   slave : the arbiter (drives gnt, fpu_x1/x2, rsp_*, busy)
interface fadd_arbiter_if;
    logic        req0;
    logic        req1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] b0;
    logic [31:0] b1;
    logic        op0;
    logic        op1;
    logic        gnt0;
    logic        gnt1;
    logic [31:0] fpu_x1;
    logic [31:0] fpu_x2;
    logic [31:0] fpu_y;
    logic        fpu_ovf;
    logic        rsp_vld0;
    logic        rsp_vld1;
    logic [31:0] rsp_y;
    logic        rsp_ovf;
    logic        busy;

    modport master (
        output req0, req1, a0, a1, b0, b1, op0, op1, fpu_y, fpu_ovf,
        input  gnt0, gnt1, fpu_x1, fpu_x2, rsp_vld0, rsp_vld1, rsp_y, rsp_ovf, busy
    );

    modport slave (
        input  req0, req1, a0, a1, b0, b1, op0, op1, fpu_y, fpu_ovf,
        output gnt0, gnt1, fpu_x1, fpu_x2, rsp_vld0, rsp_vld1, rsp_y, rsp_ovf, busy
    );
endinterface

// File: rtl/fadd_arbiter.sv
// fadd_arbiter: round-robin arbiter sharing one 2-stage fp subtractor between two requesters
//   clk  : sole clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : fadd_arbiter_if.slave
//          req0/1, a0/1, b0/1, op0/1 in; gnt0/1 out (combinational)
//          fpu_x1/x2 out to subtractor, fpu_y/fpu_ovf back two cycles after issue
//          rsp_vld0/1, rsp_y, rsp_ovf registered responses (3 cycles after grant), busy
//   FADD_ARBITER_ADD_EN: when defined, op=1 selects a+b by flipping the sign of b;
//                        otherwise op inputs are ignored and every operation is a-b.
module fadd_arbiter (
    input logic           clk,
    input logic           rstn,
    fadd_arbiter_if.slave bus
);
    logic        last;
    logic        g0;
    logic        g1;
    logic        add0;
    logic        add1;
    logic [31:0] b_sel;
    logic        add_sel;
    logic        s1_vld;
    logic        s1_tag;
    logic        s2_vld;
    logic        s2_tag;
    logic        rsp_vld0;
    logic        rsp_vld1;
    logic [31:0] rsp_y;
    logic        rsp_ovf;

`ifdef FADD_ARBITER_ADD_EN
    assign add0 = bus.op0;
    assign add1 = bus.op1;
`else
    logic unused_op;
    assign unused_op = bus.op0 ^ bus.op1;
    assign add0 = 1'b0;
    assign add1 = 1'b0;
`endif

    // last is the most recently granted requester; a tie goes to the other one.
    always_comb begin
        g0      = rstn & bus.req0 & (~bus.req1 | last);
        g1      = rstn & bus.req1 & (~bus.req0 | ~last);
        b_sel   = g0 ? bus.b0 : g1 ? bus.b1 : 32'h0;
        add_sel = g0 ? add0 : g1 & add1;
    end

    assign bus.gnt0   = g0;
    assign bus.gnt1   = g1;
    assign bus.fpu_x1 = g0 ? bus.a0 : g1 ? bus.a1 : 32'h0;
    assign bus.fpu_x2 = add_sel ? {~b_sel[31], b_sel[30:0]} : b_sel;

    // s1/s2 track valid and tag alongside the subtractor's two stages.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last     <= 1'b1;
            s1_vld   <= 1'b0;
            s1_tag   <= 1'b0;
            s2_vld   <= 1'b0;
            s2_tag   <= 1'b0;
            rsp_vld0 <= 1'b0;
            rsp_vld1 <= 1'b0;
            rsp_y    <= 32'h0;
            rsp_ovf  <= 1'b0;
        end else begin
            if (g0 | g1) last <= g1;
            s1_vld   <= g0 | g1;
            s1_tag   <= g1;
            s2_vld   <= s1_vld;
            s2_tag   <= s1_tag;
            rsp_vld0 <= s2_vld & ~s2_tag;
            rsp_vld1 <= s2_vld & s2_tag;
            if (s2_vld) begin
                rsp_y   <= bus.fpu_y;
                rsp_ovf <= bus.fpu_ovf;
            end
        end
    end

    assign bus.rsp_vld0 = rsp_vld0;
    assign bus.rsp_vld1 = rsp_vld1;
    assign bus.rsp_y    = rsp_y;
    assign bus.rsp_ovf  = rsp_ovf;
    assign bus.busy     = s1_vld | s2_vld;
endmodule
